// File: rtl/dance_pkg.sv
// Shared definitions for the dance-step game datapath: judgement codes
// (also decoded by the score/streak updater) and the per-lane window state.
package dance_pkg;

  localparam logic [1:0] JUDGE_NONE    = 2'b00;
  localparam logic [1:0] JUDGE_OK      = 2'b01;
  localparam logic [1:0] JUDGE_PERFECT = 2'b10;
  localparam logic [1:0] JUDGE_MISS    = 2'b11;

  typedef enum logic {
    LANE_IDLE = 1'b0,
    LANE_OPEN = 1'b1
  } lane_state_t;

endpackage

// File: rtl/hit_lane.sv
// One arrow lane: key synchroniser and edge detect, hit-window FSM with tick
// counter, and a single-entry pending judgement slot. HIT_JUDGE_BAD_PRESS_EN
// makes presses on an idle lane produce a BAD judgement.
module hit_lane
  import dance_pkg::*;
#(
  parameter int WINDOW_TICKS = 200,
  parameter int PERF_LO      = 75,
  parameter int PERF_HI      = 125
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       game_active,
  input  logic       note_open,
  input  logic       key,
  input  logic       issue,
  output logic       slot_valid,
  output logic [1:0] slot_code,
  output logic       overwrite
);

  localparam int CW = $clog2(WINDOW_TICKS + 1);

  logic key_meta, key_sync, key_prev;
  logic press;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  assign press = key_sync & ~key_prev;

  lane_state_t     state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic            expire, in_perf;
  logic            gen_valid;
  logic [1:0]      gen_code;

  assign cnt_inc = cnt_reg + 1'b1;
  assign expire  = tick && (cnt_inc == CW'(WINDOW_TICKS));
  assign in_perf = (cnt_reg >= CW'(PERF_LO)) && (cnt_reg < CW'(PERF_HI));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gen_valid  = 1'b0;
    gen_code   = JUDGE_NONE;
    if (!game_active) begin
      state_next = LANE_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        LANE_IDLE: begin
          if (note_open) begin
            state_next = LANE_OPEN;
            cnt_next   = '0;
          end
`ifdef HIT_JUDGE_BAD_PRESS_EN
          if (press) begin
            gen_valid = 1'b1;
            gen_code  = JUDGE_MISS;
          end
`endif
        end
        LANE_OPEN: begin
          // A press always judges the current note; a simultaneous expiry
          // degrades it to OK, a simultaneous note_open starts a new window.
          if (press) begin
            gen_valid  = 1'b1;
            gen_code   = (in_perf && !expire) ? JUDGE_PERFECT : JUDGE_OK;
            state_next = note_open ? LANE_OPEN : LANE_IDLE;
            cnt_next   = '0;
          end else if (note_open) begin
            gen_valid = 1'b1;
            gen_code  = JUDGE_MISS;
            cnt_next  = '0;
          end else if (tick) begin
            if (expire) begin
              gen_valid  = 1'b1;
              gen_code   = JUDGE_MISS;
              state_next = LANE_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end
        end
        default: begin
          state_next = LANE_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= LANE_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A slot being issued this cycle frees up, so a fresh judgement is no loss.
  assign overwrite = game_active && gen_valid && slot_valid && !issue;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_valid <= 1'b0;
      slot_code  <= JUDGE_NONE;
    end else if (!game_active) begin
      slot_valid <= 1'b0;
      slot_code  <= JUDGE_NONE;
    end else if (gen_valid) begin
      slot_valid <= 1'b1;
      slot_code  <= gen_code;
    end else if (issue) begin
      slot_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Per-lane timing judge: LANES hit_lane instances plus a fixed-priority issuer
// that serialises pending judgements onto one registered code bus.
// Optional feature macro: HIT_JUDGE_BAD_PRESS_EN (see hit_lane).
module hit_judge
  import dance_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int WINDOW_TICKS = 200,
  parameter int PERF_LO      = 75,
  parameter int PERF_HI      = 125
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     tick,
  input  logic                     game_active,
  input  logic [LANES-1:0]         note_open,
  input  logic [LANES-1:0]         key,
  output logic [1:0]               judge_code,
  output logic [$clog2(LANES)-1:0] judge_lane,
  output logic                     overrun
);

  localparam int LW = $clog2(LANES);

  logic [LANES-1:0] slot_valid;
  logic [1:0]       slot_code [LANES];
  logic [LANES-1:0] overwrite;
  logic [LANES-1:0] grant;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    hit_lane #(
      .WINDOW_TICKS(WINDOW_TICKS),
      .PERF_LO     (PERF_LO),
      .PERF_HI     (PERF_HI)
    ) u_lane (
      .clk        (clk),
      .resetn     (resetn),
      .tick       (tick),
      .game_active(game_active),
      .note_open  (note_open[gi]),
      .key        (key[gi]),
      .issue      (grant[gi]),
      .slot_valid (slot_valid[gi]),
      .slot_code  (slot_code[gi]),
      .overwrite  (overwrite[gi])
    );
  end

  logic [1:0]    code_next;
  logic [LW-1:0] lane_next;
  logic          found;

  // Lowest-numbered pending lane wins the bus this cycle.
  always_comb begin
    grant     = '0;
    code_next = JUDGE_NONE;
    lane_next = '0;
    found     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (slot_valid[i] && !found) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        code_next = slot_code[i];
        lane_next = LW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      judge_code <= JUDGE_NONE;
      judge_lane <= '0;
      overrun    <= 1'b0;
    end else if (!game_active) begin
      judge_code <= JUDGE_NONE;
      judge_lane <= '0;
      overrun    <= 1'b0;
    end else begin
      judge_code <= code_next;
      judge_lane <= lane_next;
      overrun    <= overrun | (|overwrite);
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: a cycle-stamped reference model predicts
// every issued judgement; a monitor checks the code bus each cycle.
module tb_hit_judge;

  localparam int LANES = 4;
  localparam int W     = 200;
  localparam int LO    = 75;
  localparam int HI    = 125;
`ifdef HIT_JUDGE_BAD_PRESS_EN
  localparam int BAD_EN = 1;
`else
  localparam int BAD_EN = 0;
`endif

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic             tick = 1'b0;
  logic             game_active = 1'b0;
  logic [LANES-1:0] note_open = '0;
  logic [LANES-1:0] key = '0;
  logic [1:0]       judge_code;
  logic [1:0]       judge_lane;
  logic             overrun;

  hit_judge #(.LANES(LANES), .WINDOW_TICKS(W), .PERF_LO(LO), .PERF_HI(HI)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .game_active(game_active),
    .note_open(note_open), .key(key), .judge_code(judge_code),
    .judge_lane(judge_lane), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int lane; logic [1:0] code;} exp_t;
  exp_t sbq[$];

  // Reference model state
  logic [LANES-1:0] m_meta = '0, m_sync = '0, m_prev = '0;
  bit               m_open [LANES];
  int               m_t    [LANES];
  bit               m_pv   [LANES];
  logic [1:0]       m_pc   [LANES];
  bit               m_ovr = 0;
  logic [LANES-1:0] key_lvl = '0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_clear(input bit hist);
    for (int i = 0; i < LANES; i++) begin
      m_open[i] = 0; m_t[i] = 0; m_pv[i] = 0; m_pc[i] = 2'b00;
    end
    m_ovr = 0;
    if (hist) begin m_meta = '0; m_sync = '0; m_prev = '0; end
  endtask

  // What the spec says happens at the coming clock edge.
  task automatic model_step(input bit t, input logic [LANES-1:0] no, input bit ga);
    logic [LANES-1:0] press;
    bit               gen, done;
    logic [1:0]       code;
    press  = m_sync & ~m_prev;
    m_prev = m_sync; m_sync = m_meta; m_meta = key_lvl;
    if (!ga) begin model_clear(0); return; end
    done = 0;
    for (int i = 0; i < LANES; i++)
      if (m_pv[i] && !done) begin
        sbq.push_back('{cyc + 1, i, m_pc[i]});
        m_pv[i] = 0; done = 1;
      end
    for (int i = 0; i < LANES; i++) begin
      gen = 0; code = 2'b00;
      if (m_open[i]) begin
        if (press[i]) begin
          gen = 1;
          code = (m_t[i] >= LO && m_t[i] < HI && !(t && m_t[i] + 1 == W)) ? 2'b10 : 2'b01;
          m_open[i] = no[i]; m_t[i] = 0;
        end else if (no[i]) begin
          gen = 1; code = 2'b11; m_t[i] = 0;
        end else if (t) begin
          m_t[i]++;
          if (m_t[i] == W) begin gen = 1; code = 2'b11; m_open[i] = 0; m_t[i] = 0; end
        end
      end else begin
        if (no[i]) begin m_open[i] = 1; m_t[i] = 0; end
        if (BAD_EN != 0 && press[i]) begin gen = 1; code = 2'b11; end
      end
      if (gen) begin
        if (m_pv[i]) m_ovr = 1;
        m_pv[i] = 1; m_pc[i] = code;
      end
    end
  endtask

  task automatic apply(input bit t, input logic [LANES-1:0] no, input bit ga);
    tick = t; note_open = no; key = key_lvl; game_active = ga;
    model_step(t, no, ga);
  endtask

  task automatic cyc_step(input bit t, input logic [LANES-1:0] no, input bit ga);
    @(negedge clk);
    check("overrun", int'(overrun), int'(m_ovr));
    apply(t, no, ga);
  endtask

  task automatic run(input int n, input bit t);
    repeat (n) cyc_step(t, '0, 1'b1);
  endtask

  task automatic idle_all();
    cyc_step(1'b0, '0, 1'b0);
    run(3, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check("overrun", int'(overrun), int'(m_ovr));
    #1;
    resetn = 1'b0; tick = 1'b0; note_open = '0;
    model_clear(1);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    apply(1'b0, '0, 1'b1);
  endtask

  // Monitor: compares the bus every cycle against the scoreboard.
  bit         mon_en = 0;
  int         issue_cnt = 0;
  logic [1:0] last_code = 2'b00;
  int         last_lane = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      int         want_lane;
      logic [1:0] want_code;
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        void'(sbq.pop_front());
        checks++; errors++;
        $display("FAIL stale_expect: judgement never observed (cycle %0d)", cyc);
      end
      want_lane = 0; want_code = 2'b00;
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        want_lane = e.lane; want_code = e.code;
      end
      checks++;
      if (judge_code !== want_code || int'(judge_lane) != want_lane) begin
        errors++;
        $display("FAIL judge_bus: got code=%b lane=%0d, expected code=%b lane=%0d (cycle %0d)",
                 judge_code, judge_lane, want_code, want_lane, cyc);
      end
      if (judge_code != 2'b00) begin
        issue_cnt++; last_code = judge_code; last_lane = int'(judge_lane);
      end
    end
  end

  int n0;

  task automatic hit_test(input int lane, input int x, input logic [1:0] want);
    idle_all();
    #1 n0 = issue_cnt;
    cyc_step(1'b1, LANES'(1) << lane, 1'b1);
    run(x - 2, 1'b1);
    key_lvl[lane] = 1'b1;
    cyc_step(1'b1, '0, 1'b1);
    run(6, 1'b1);
    key_lvl[lane] = 1'b0;
    run(4, 1'b1);
    #1;
    check($sformatf("hit_count_t%0d", x), issue_cnt - n0, 1);
    check($sformatf("hit_code_t%0d", x), int'(last_code), int'(want));
    check($sformatf("hit_lane_t%0d", x), last_lane, lane);
  endtask

  initial begin
    model_clear(1);
    #2 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_code", int'(judge_code), 0);
    check("reset_lane", int'(judge_lane), 0);
    check("reset_overrun", int'(overrun), 0);
    mon_en = 1;
    resetn = 1'b1;
    apply(1'b0, '0, 1'b1);

    hit_test(0, 100, 2'b10);
    hit_test(1, 10, 2'b01);
    hit_test(2, 124, 2'b10);
    hit_test(3, 125, 2'b01);
    hit_test(0, 75, 2'b10);

    // Timeout
    idle_all();
    #1 n0 = issue_cnt;
    cyc_step(1'b1, 4'b0001, 1'b1);
    run(205, 1'b1);
    #1;
    check("timeout_count", issue_cnt - n0, 1);
    check("timeout_code", int'(last_code), 3);

    // Contention: lanes 1..3 miss together
    idle_all();
    #1 n0 = issue_cnt;
    cyc_step(1'b0, 4'b1110, 1'b1);
    run(3, 1'b0);
    cyc_step(1'b0, 4'b1110, 1'b1);
    run(6, 1'b0);
    #1;
    check("contention_count", issue_cnt - n0, 3);
    check("contention_last_lane", last_lane, 3);
    check("contention_overrun", int'(overrun), 0);

    // Overwrite: lane 3 waits behind lanes 0..2, then a press replaces its MISS
    idle_all();
    #1 n0 = issue_cnt;
    cyc_step(1'b0, 4'b1111, 1'b1);
    run(3, 1'b0);
    key_lvl[3] = 1'b1;
    cyc_step(1'b0, '0, 1'b1);
    cyc_step(1'b0, 4'b1111, 1'b1);
    run(8, 1'b0);
    key_lvl[3] = 1'b0;
    run(3, 1'b0);
    #1;
    check("overwrite_count", issue_cnt - n0, 4);
    check("overwrite_code", int'(last_code), 1);
    check("overwrite_lane", last_lane, 3);
    check("overwrite_overrun", int'(overrun), 1);
    cyc_step(1'b0, '0, 1'b0);
    cyc_step(1'b0, '0, 1'b1);
    #1 check("overrun_cleared", int'(overrun), 0);

    // Press on an idle lane
    idle_all();
    #1 n0 = issue_cnt;
    key_lvl[2] = 1'b1;
    run(6, 1'b0);
    key_lvl[2] = 1'b0;
    run(4, 1'b0);
    #1 check("idle_press_count", issue_cnt - n0, BAD_EN);

    // Abort by game_active at tick 50
    idle_all();
    cyc_step(1'b1, 4'b0001, 1'b1);
    run(50, 1'b1);
    cyc_step(1'b1, '0, 1'b0);
    cyc_step(1'b1, '0, 1'b1);
    #1;
    check("abort_code", int'(judge_code), 0);
    n0 = issue_cnt;
    key_lvl[0] = 1'b1;
    run(6, 1'b1);
    key_lvl[0] = 1'b0;
    run(4, 1'b1);
    #1 check("abort_press_count", issue_cnt - n0, BAD_EN);

    // Abort by reset at tick 50
    cyc_step(1'b1, 4'b0010, 1'b1);
    run(50, 1'b1);
    do_reset();
    #1;
    check("rst_abort_code", int'(judge_code), 0);
    n0 = issue_cnt;
    key_lvl[1] = 1'b1;
    run(6, 1'b1);
    key_lvl[1] = 1'b0;
    run(4, 1'b1);
    #1 check("rst_abort_press_count", issue_cnt - n0, BAD_EN);

    // Randomised traffic against the model
    for (int n = 0; n < 6000; n++) begin
      logic [LANES-1:0] no;
      no = '0;
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 149) == 0) no[i] = 1'b1;
        if ($urandom_range(0, 49) == 0) key_lvl[i] = ~key_lvl[i];
      end
      if ($urandom_range(0, 2999) == 0) do_reset();
      else cyc_step(1'($urandom_range(0, 1)), no, ($urandom_range(0, 1499) != 0));
    end

    run(10, 1'b0);
    #1 check("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
